wb_regfile: RTL and testbench

Writeback-side consumer of the MEM/WB pipeline register. It commits the writeback result into the 32x32 general register file, serves the two decode-stage read ports with write-through bypass, and keeps a retired-instruction counter. It also emits a registered commit trace for the bench and logging. It sits between the MEM/WB register outputs and the decode stage / hazard logic.

---
 rtl/wb_regfile_pkg.sv | 14 +
 rtl/wb_regfile_array.sv | 31 +++
 rtl/wb_regfile.sv | 91 +++++++++
 tb/tb_wb_regfile.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: constants shared by the writeback register file, the MEM/WB register and the hazard unit.
package wb_regfile_pkg;
    localparam int          DATA_W     = 32;
    localparam int          REG_ADDR_W = 5;
    localparam int          NREG       = 32;
    localparam int          CNT_W      = 32;
    localparam logic [4:0]  REG_ZERO   = 5'd0;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] PC_RESET   = 32'h0000_3000;

    function automatic logic is_commit(input logic we, input logic [REG_ADDR_W-1:0] dst, input logic rst);
        return we && (dst != REG_ZERO) && !rst;
    endfunction
endpackage

// File: rtl/wb_regfile_array.sv
// wb_regfile_array: NREG x DATA_W register storage, one synchronous write port, two combinational reads, $0 hardwired.
module wb_regfile_array #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr_a,
    input  logic [AW-1:0]     i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);
    import wb_regfile_pkg::*;

    logic [DATA_W-1:0] r_regs [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (i_we && i_waddr != REG_ZERO) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == REG_ZERO) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == REG_ZERO) ? '0 : r_regs[i_raddr_b];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: commits MEM/WB results to the register file, serves two bypassed decode reads,
// counts retired instructions and emits a one-cycle-delayed commit trace.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int CNT_W  = 32,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       wb_instr,
    input  logic [31:0]       wb_pc,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [AW-1:0]     rs_addr,
    input  logic [AW-1:0]     rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [CNT_W-1:0]  instret,
    output logic              trace_valid,
    output logic [31:0]       trace_pc,
    output logic [AW-1:0]     trace_dst,
    output logic [DATA_W-1:0] trace_data
);
    import wb_regfile_pkg::*;

    logic              w_commit;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [CNT_W-1:0]  r_instret;
    logic              r_trace_valid;
    logic [31:0]       r_trace_pc;
    logic [AW-1:0]     r_trace_dst;
    logic [DATA_W-1:0] r_trace_data;

    assign w_commit = is_commit(wb_we, wb_dst, reset);

    wb_regfile_array #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (AW)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_commit),
        .i_waddr   (wb_dst),
        .i_wdata   (wb_data),
        .i_raddr_a (rs_addr),
        .i_raddr_b (rt_addr),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    // Same-cycle write-through so decode never sees a stale value for the register being committed.
    always_comb begin
        rs_data = (rs_addr == REG_ZERO) ? '0 : (w_commit && rs_addr == wb_dst) ? wb_data : w_rd_a;
        rt_data = (rt_addr == REG_ZERO) ? '0 : (w_commit && rt_addr == wb_dst) ? wb_data : w_rd_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret <= '0;
        end else if (wb_instr != NOP_INSTR) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Payload only loads on a commit, so it keeps the last committed write between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_trace_valid <= 1'b0;
            r_trace_pc    <= PC_RESET;
            r_trace_dst   <= '0;
            r_trace_data  <= '0;
        end else begin
            r_trace_valid <= w_commit;
            if (w_commit) begin
                r_trace_pc   <= wb_pc;
                r_trace_dst  <= wb_dst;
                r_trace_data <= wb_data;
            end
        end
    end

    assign instret     = r_instret;
    assign trace_valid = r_trace_valid;
    assign trace_pc    = r_trace_pc;
    assign trace_dst   = r_trace_dst;
    assign trace_data  = r_trace_data;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized and directed stimulus against an array-based reference model,
// with a scoreboard queue of per-cycle expectations and a queue of expected trace pulses.
module tb_wb_regfile;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      wb_instr = '0;
    logic [31:0]      wb_pc = '0;
    logic             wb_we = 1'b0;
    logic [4:0]       wb_dst = '0;
    logic [31:0]      wb_data = '0;
    logic [4:0]       rs_addr = '0;
    logic [4:0]       rt_addr = '0;
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
    logic [CNT_W-1:0] instret;
    logic             trace_valid;
    logic [31:0]      trace_pc;
    logic [4:0]       trace_dst;
    logic [31:0]      trace_data;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(32), .NREG(32), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_instr    (wb_instr),
        .wb_pc       (wb_pc),
        .wb_we       (wb_we),
        .wb_dst      (wb_dst),
        .wb_data     (wb_data),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .instret     (instret),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_dst   (trace_dst),
        .trace_data  (trace_data)
    );

    typedef struct {
        bit               chk;
        logic [31:0]      rs;
        logic [31:0]      rt;
        logic [CNT_W-1:0] ir;
        logic             tv;
        logic [31:0]      tpc;
        logic [4:0]       tdst;
        logic [31:0]      tdata;
    } rec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  dst;
        logic [31:0] data;
    } trace_t;

    rec_t   rq[$];
    trace_t tq[$];

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]      m_regs [32];
    logic [CNT_W-1:0] m_ir;
    bit               m_init = 0;
    logic             m_tv;
    logic [31:0]      m_tpc;
    logic [4:0]       m_tdst;
    logic [31:0]      m_tdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit c, input logic [4:0] d, input logic [31:0] v);
        if (a == 0) return 32'h0;
        if (c && a == d) return v;
        return m_regs[a];
    endfunction

    task automatic step(input bit r, input logic [31:0] ins, input logic [31:0] pc, input bit we,
                        input logic [4:0] dst, input logic [31:0] dat, input logic [4:0] ra, input logic [4:0] rb);
        rec_t   e;
        trace_t t;
        bit     c;
        @(posedge clk);
        #1;
        reset = r; wb_instr = ins; wb_pc = pc; wb_we = we; wb_dst = dst; wb_data = dat;
        rs_addr = ra; rt_addr = rb;
        c = !r && we && dst != 0;
        e.chk = m_init;
        e.rs = m_read(ra, c, dst, dat);
        e.rt = m_read(rb, c, dst, dat);
        e.ir = m_ir; e.tv = m_tv; e.tpc = m_tpc; e.tdst = m_tdst; e.tdata = m_tdata;
        rq.push_back(e);
        if (r) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            m_ir = '0; m_tv = 1'b0; m_tpc = 32'h0000_3000; m_tdst = '0; m_tdata = '0;
            m_init = 1;
        end else begin
            if (ins != 0) m_ir = m_ir + 1'b1;
            m_tv = c;
            if (c) begin
                m_regs[dst] = dat;
                m_tpc = pc; m_tdst = dst; m_tdata = dat;
                t.pc = pc; t.dst = dst; t.data = dat;
                tq.push_back(t);
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        rec_t   e;
        trace_t t;
        if (rq.size() > 0) begin
            e = rq.pop_front();
            if (e.chk) begin
                chk("rs_data", rs_data, e.rs);
                chk("rt_data", rt_data, e.rt);
                chk("instret", {{(32-CNT_W){1'b0}}, instret}, {{(32-CNT_W){1'b0}}, e.ir});
                chk("trace_valid", {31'b0, trace_valid}, {31'b0, e.tv});
                chk("trace_pc_hold", trace_pc, e.tpc);
                chk("trace_dst_hold", {27'b0, trace_dst}, {27'b0, e.tdst});
                chk("trace_data_hold", trace_data, e.tdata);
            end
        end
        if (trace_valid === 1'b1) begin
            if (tq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL trace_spurious: got pulse dst %0d expected none at %0t", trace_dst, $time);
            end else begin
                t = tq.pop_front();
                chk("trace_pc", trace_pc, t.pc);
                chk("trace_dst", {27'b0, trace_dst}, {27'b0, t.dst});
                chk("trace_data", trace_data, t.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ins;
        logic [4:0]  d;
        bit          r;
        bit          we;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 5'(2*i), 5'(2*i+1));
        step(0, 32'h3C05DEAD, 32'h3004, 1, 5, 32'hDEADBEEF, 5, 0);
        step(0, 0, 0, 0, 0, 0, 5, 5);
        step(0, 32'h2000_0001, 32'h3008, 1, 0, 32'h12345678, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 5);
        repeat (3) step(0, 0, 0, 0, 0, 0, 5, 0);
        step(0, 32'h1, 32'h300C, 1, 7, 32'h55, 7, 0);
        step(1, 32'h1, 32'h3010, 1, 7, 32'hAA, 7, 5);
        step(0, 0, 0, 0, 0, 0, 7, 5);
        step(0, 32'h1, 32'h3014, 1, 31, 32'h0000_3008, 31, 31);
        step(0, 32'h1, 32'h3018, 1, 31, 32'h1, 31, 31);
        step(0, 0, 0, 0, 0, 0, 31, 31);
        step(0, 32'h1, 32'h301C, 1, 9, 32'h99, 9, 9);
        step(0, 32'h1, 32'h3020, 1, 9, 32'h77, 9, 31);
        for (int i = 0; i < 300; i++) step(0, 32'h1, 32'h4000 + 32'(4*i), 0, 0, 0, 31, 9);
        for (int i = 0; i < 1200; i++) begin
            r   = ($urandom_range(0, 63) == 0);
            ins = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h1);
            we  = (ins != 0) && ($urandom_range(0, 2) != 0);
            d   = 5'($urandom_range(0, 31));
            step(r, ins, $urandom, we, d, $urandom,
                 ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        vectors++;
        if (tq.size() != 0) begin
            miscompares++;
            $display("FAIL trace_missing: got %0d unmatched expected 0", tq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
